// File: rtl/exu_div.sv
`default_nettype none
// ============================================================================
//  Module   : exu_div
//  Purpose  : Execute-stage 32-bit integer divider (DIV/DIVU/REM/REMU).
//             Restoring shift-subtract on magnitudes, one step per cycle,
//             with early completion for divide-by-zero and signed overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module exu_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [3:0]  op_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [4:0]  rd_waddr_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_waddr_o,
  output logic        rd_we_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_END  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic [31:0] dvs_q, dvs_d;     // divisor magnitude
  logic        negq_q, negq_d;   // quotient must be negated at the end
  logic        negr_q, negr_d;   // remainder must be negated at the end
  logic        selr_q, selr_d;   // result is the remainder rather than the quotient
  logic [4:0]  rd_q, rd_d;

  logic        busy_w;
  logic        signed_op, rem_op, a_neg, b_neg, div_zero, ovf;
  logic [31:0] a_abs, b_abs, quo_res, rem_res;
  logic [32:0] partial, diff;

  // Operand decode for the accept cycle
  always_comb begin
    signed_op = op_i[0] | op_i[2];
    rem_op    = op_i[2] | op_i[3];
    a_neg     = signed_op & dividend_i[31];
    b_neg     = signed_op & divisor_i[31];
    a_abs     = a_neg ? (32'd0 - dividend_i) : dividend_i;
    b_abs     = b_neg ? (32'd0 - divisor_i)  : divisor_i;
    div_zero  = (divisor_i == 32'd0);
    ovf       = signed_op && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
    partial   = {rem_q, quo_q[31]};
    diff      = partial - {1'b0, dvs_q};
  end

  // Next-state, datapath step and stall request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    selr_d  = selr_q;
    rd_d    = rd_q;
    busy_w  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          busy_w = 1'b1;
          cnt_d  = 5'd0;
          selr_d = rem_op;
          rd_d   = rd_waddr_i;
          if (div_zero) begin
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = dividend_i;
            dvs_d   = 32'd0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_END;
          end else if (ovf) begin
            quo_d   = 32'h8000_0000;
            rem_d   = 32'd0;
            dvs_d   = 32'd0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_END;
          end else begin
            quo_d   = a_abs;
            rem_d   = 32'd0;
            dvs_d   = b_abs;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        busy_w = 1'b1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = partial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_END;
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A flush abandons whatever is in flight and drops the latched operands
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      quo_d   = 32'd0;
      rem_d   = 32'd0;
      dvs_d   = 32'd0;
      negq_d  = 1'b0;
      negr_d  = 1'b0;
      selr_d  = 1'b0;
      rd_d    = 5'd0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      selr_q  <= 1'b0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      selr_q  <= selr_d;
      rd_q    <= rd_d;
    end
  end

  // Sign fix-up and zero-gated write-back outputs
  always_comb begin
    quo_res    = negq_q ? (32'd0 - quo_q) : quo_q;
    rem_res    = negr_q ? (32'd0 - rem_q) : rem_q;
    busy_o     = rst_n & busy_w;
    ready_o    = (state_q == S_END) && !flush_i;
    rd_we_o    = ready_o;
    result_o   = ready_o ? (selr_q ? rem_res : quo_res) : 32'd0;
    rd_waddr_o = ready_o ? rd_q : 5'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_exu_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exu_div
//  Purpose  : Self-checking bench for exu_div with an arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exu_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dividend_i, divisor_i;
  logic [3:0]  op_i;
  logic        start_i, flush_i;
  logic [4:0]  rd_waddr_i;
  logic        busy_o, ready_o, rd_we_o;
  logic [31:0] result_o;
  logic [4:0]  rd_waddr_o;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] OP_DIV = 4'b0001, OP_DIVU = 4'b0010, OP_REM = 4'b0100, OP_REMU = 4'b1000;

  exu_div dut (
    .clk(clk), .rst_n(rst_n), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .op_i(op_i), .start_i(start_i), .flush_i(flush_i), .rd_waddr_i(rd_waddr_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
    .rd_waddr_o(rd_waddr_o), .rd_we_o(rd_we_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ||
           ((op[0] || op[2]) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference result straight from the arithmetic definition of each opcode
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    bit is_rem, is_signed;
    sa = a; sb = b;
    is_rem    = op[2] || op[3];
    is_signed = op[0] || op[2];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'd0 : 32'h8000_0000;
    if (is_signed) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Issue one operation, follow it to completion and check timing and write-back
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold);
    logic [31:0] exp;
    int exp_lat, lat, bcnt;
    bit leak;
    exp     = model(op, a, b);
    exp_lat = is_special(op, a, b) ? 2 : 34;
    @(negedge clk);
    dividend_i = a; divisor_i = b; op_i = op; rd_waddr_i = rd; start_i = 1'b1;
    lat = 0; bcnt = 0; leak = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (ready_o) begin
        lat = c;
        break;
      end
      if (busy_o) bcnt++;
      if (result_o !== 32'd0 || rd_waddr_o !== 5'd0 || rd_we_o !== 1'b0) leak = 1'b1;
      @(negedge clk);
      dividend_i = $urandom; divisor_i = $urandom; rd_waddr_i = 5'($urandom);
      op_i = 4'b0001 << $urandom_range(0, 3);
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", bcnt, exp_lat - 1);
    check("result", result_o, exp);
    check("rd_waddr", {27'd0, rd_waddr_o}, {27'd0, rd});
    check("rd_we", {31'd0, rd_we_o}, 32'd1);
    check("idle_outputs_zero", {31'd0, leak}, 32'd0);
    start_i = hold;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int sel;
    bit seen;

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    dividend_i = '0; divisor_i = '0; op_i = '0; rd_waddr_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_rd", {27'd0, rd_waddr_o}, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b0);
    run_op(OP_REMU, 32'd100, 32'd7, 5'd5, 1'b0);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd1, 1'b0);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd2, 1'b0);
    run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd3, 1'b0);
    run_op(OP_DIVU, 32'h1234, 32'd0, 5'd4, 1'b0);
    run_op(OP_REMU, 32'h1234, 32'd0, 5'd6, 1'b0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 1'b0);

    // Flush during CALC step 10
    @(negedge clk);
    dividend_i = 32'hDEAD_BEEF; divisor_i = 32'd13; op_i = OP_DIVU; rd_waddr_i = 5'd9; start_i = 1'b1;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_ready", {31'd0, ready_o}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (ready_o || rd_we_o) seen = 1'b1;
    end
    check("flush_no_ready", {31'd0, seen}, 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd10, 1'b0);

    // Flush together with start in IDLE must not start anything
    @(negedge clk);
    dividend_i = 32'd50; divisor_i = 32'd5; op_i = OP_DIVU; start_i = 1'b1; flush_i = 1'b1;
    #1;
    check("flush_start_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flush_start_idle", {31'd0, busy_o | ready_o}, 32'd0);

    // Asynchronous reset during CALC step 20
    @(negedge clk);
    dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd3; op_i = OP_DIVU; rd_waddr_i = 5'd7; start_i = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o | rd_we_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", {27'd0, rd_waddr_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst_n = 1'b1;
    run_op(OP_DIVU, 32'd1, 32'd1, 5'd11, 1'b0);

    // Back-to-back with start held through END
    run_op(OP_DIVU, 32'd1000, 32'd10, 5'd12, 1'b1);
    run_op(OP_REM,  32'hFFFF_FF00, 32'd7, 5'd13, 1'b1);
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd14, 1'b0);
    @(negedge clk); #1;
    check("b2b_no_dup", {31'd0, ready_o | busy_o}, 32'd0);

    // Randomized operations against the reference
    for (int i = 0; i < 30; i++) begin
      rop = 4'b0001 << $urandom_range(0, 3);
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = 32'($urandom_range(0, 400)) - 32'd200; rb = 32'($urandom_range(1, 20)) - 32'd10; end
      else if (sel == 3) rb = 32'($urandom_range(1, 0 + 255));
      run_op(rop, ra, rb, 5'($urandom), 1'($urandom_range(0, 1)));
    end
    start_i = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exu_div.md
EXU_DIV -- requirements
Module: exu_div

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits.
REQ-002 SHALL provide: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide: dividend_i  input  32  rs1 operand from the ID/EX pipeline register.
REQ-005 SHALL provide: divisor_i  input  32  rs2 operand from the ID/EX pipeline register.
REQ-006 SHALL provide: op_i  input  4  one-hot opcode: [0] DIV, [1] DIVU, [2] REM, [3] REMU.
REQ-007 SHALL provide: start_i  input  1  request; held high by the pipeline while the instruction sits in EX.
REQ-008 SHALL provide: flush_i  input  1  pipeline flush, aborts the current operation.
REQ-009 SHALL provide: rd_waddr_i  input  5  destination register of the divide instruction.
REQ-010 SHALL provide: busy_o  output  1  stall request to the pipeline (drives the EX stall bit).
REQ-011 SHALL provide: ready_o  output  1  result-valid strobe, one cycle.
REQ-012 SHALL provide: result_o  output  32  quotient or remainder.
REQ-013 SHALL provide: rd_waddr_o  output  5  latched destination register.
REQ-014 SHALL provide: rd_we_o  output  1  register write enable, equals ready_o.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, END.
REQ-016 IDLE: start_i=1 and flush_i=0 SHALL latch operands, op_i, rd_waddr_i; go to END if special case (REQ-022/023), else CALC.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle on absolute values, 32 steps counted by a 5-bit counter, then go to END.
REQ-018 END SHALL assert ready_o for exactly one cycle, then go to IDLE unconditionally; start_i is not sampled in END.
REQ-019 busy_o SHALL be combinational: 1 when (IDLE and start_i and !flush_i) or state==CALC; 0 in END and otherwise.
REQ-020 Latency SHALL be: normal op, ready_o high in the 34th cycle counting the accept cycle as 1; special case, ready_o high in the 2nd cycle.
REQ-021 DIV/REM SHALL treat operands as two's complement: quotient negated when operand signs differ, remainder takes dividend's sign; DIVU/REMU unsigned.
REQ-022 Divisor==0 SHALL give quotient 0xFFFFFFFF and remainder = dividend, no iteration.
REQ-023 DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0, no iteration.
REQ-024 result_o, rd_waddr_o, rd_we_o SHALL be 0 whenever ready_o=0.
REQ-025 flush_i=1 in any state SHALL force IDLE at the next edge, suppress ready_o/rd_we_o, and discard latched operands; flush and start in the same IDLE cycle SHALL not start.
REQ-026 Operand changes on inputs after acceptance SHALL not affect the running operation.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counter 0, all latched data 0, busy_o=0, ready_o=0, result_o=0, rd_waddr_o=0, rd_we_o=0, including mid-CALC.
REQ-028 After rst_n release the first start_i SHALL be accepted normally.

Verification
REQ-029 DIVU 100/7, rd=5 -> busy_o high 33 cycles, ready_o in cycle 34, result_o=14, rd_waddr_o=5, rd_we_o=1; REMU same -> 2.
REQ-030 DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE(-2) -> 0xFFFFFFFD.
REQ-031 DIVU 0x1234/0 -> 0xFFFFFFFF at cycle 2; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 Flush at CALC step 10 -> IDLE next cycle, busy_o=0, no ready_o; new DIVU 9/3 then -> 3 after 34 cycles.
REQ-033 rst_n low at CALC step 20 -> all outputs 0 immediately; after release DIVU 1/1 -> 1.
REQ-034 Back-to-back: start_i held through END then new op next cycle -> exactly one ready_o per op, no duplicate start.
